// File: rtl/adc_ads886x_multi_if.sv
// OPB-attached sequencer for NUM_CH ADS886x ADCs sharing AD_CNVST/AD_SCLK, storing frames in a sample RAM.
// Define ADS886X_SIGN_EXT_EN to sign-extend stored samples; by default the upper bits are zero-filled.
module adc_ads886x_multi_if #(
   parameter int NUM_CH   = 4,
   parameter int DATA_W   = 16,
   parameter int DEPTH    = 256,
   parameter int SCLK_DIV = 2,
   parameter int CONV_CYC = 30
) (
   input  logic              OPB_CLK,
   input  logic              OPB_RST_N,
   input  logic [31:0]       OPB_ADDR,
   input  logic [31:0]       OPB_DI,
   input  logic              OPB_WE,
   input  logic              OPB_RE,
   output logic [31:0]       OPB_DO,
   output logic              AD_CNVST,
   output logic              AD_SCLK,
   input  logic [NUM_CH-1:0] AD_SDOUT
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int DIVW  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
   localparam int BITW  = $clog2(DATA_W);
   localparam int CONVW = (CONV_CYC > 1) ? $clog2(CONV_CYC) : 1;
   localparam logic [16:0] FRAMES_MAX = 17'(DEPTH / NUM_CH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CONV,
      ST_ACQ,
      ST_STORE,
      ST_WAIT,
      ST_DONE
   } state_t;

   state_t                         state_q, state_d;
   logic                           cont_q, cont_d;
   logic                           run_cont_q, run_cont_d;
   logic [15:0]                    nsamp_q, nsamp_d;
   logic [15:0]                    period_q, period_d;
   logic                           done_q, done_d;
   logic                           ovf_q, ovf_d;
   logic [AW-1:0]                  wptr_q, wptr_d;
   logic [16:0]                    frame_q, frame_d;
   logic [16:0]                    target_q, target_d;
   logic [16:0]                    per_q, per_d;
   logic [CONVW-1:0]               cnt_q, cnt_d;
   logic [DIVW-1:0]                div_q, div_d;
   logic [BITW-1:0]                bit_q, bit_d;
   logic [CHW-1:0]                 st_q, st_d;
   logic                           sclk_q, sclk_d;
   logic                           cnvst_q, cnvst_d;
   logic [NUM_CH-1:0][DATA_W-1:0]  sh_q, sh_d;
   logic [31:0]                    do_q, do_d;

   logic [31:0]   mem [DEPTH];
   logic          mem_we;
   logic [AW-1:0] mem_wa;
   logic [31:0]   mem_wd;

   logic          reg_hit, ram_hit, ctrl_wr, soft_rst, start, busy;
   logic [1:0]    reg_idx;
   logic [AW:0]   wsum;
   logic          unused_bits;

   assign reg_hit  = (OPB_ADDR[31:4] == 28'h0000080);
   assign reg_idx  = OPB_ADDR[3:2];
   assign ram_hit  = (OPB_ADDR[31:11] == '0);
   assign ctrl_wr  = OPB_WE && reg_hit && (reg_idx == 2'd0);
   assign soft_rst = ctrl_wr && OPB_DI[0];
   assign start    = ctrl_wr && OPB_DI[1] && !OPB_DI[0];
   assign busy     = (state_q != ST_IDLE);
   assign unused_bits = ^{OPB_DI[31:16], OPB_ADDR[1:0]};

   assign OPB_DO   = do_q;
   assign AD_CNVST = cnvst_q;
   assign AD_SCLK  = sclk_q;

   function automatic logic [31:0] extend(input logic [DATA_W-1:0] s);
`ifdef ADS886X_SIGN_EXT_EN
      return {{(32-DATA_W){s[DATA_W-1]}}, s};
`else
      return {{(32-DATA_W){1'b0}}, s};
`endif
   endfunction

   always_comb begin
      state_d    = state_q;
      cont_d     = cont_q;
      run_cont_d = run_cont_q;
      nsamp_d    = nsamp_q;
      period_d   = period_q;
      done_d     = done_q;
      ovf_d      = ovf_q;
      wptr_d     = wptr_q;
      frame_d    = frame_q;
      target_d   = target_q;
      per_d      = (per_q != '1) ? per_q + 17'd1 : per_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      bit_d      = bit_q;
      st_d       = st_q;
      sclk_d     = sclk_q;
      sh_d       = sh_q;
      do_d       = '0;
      mem_we     = 1'b0;
      mem_wa     = wptr_q + AW'(st_q);
      mem_wd     = extend(sh_q[st_q]);
      wsum       = {1'b0, wptr_q} + (AW+1)'(NUM_CH);

      if (OPB_WE && reg_hit) begin
         case (reg_idx)
            2'd0:    cont_d   = OPB_DI[2];
            2'd1:    nsamp_d  = OPB_DI[15:0];
            2'd3:    period_d = OPB_DI[15:0];
            default: ;
         endcase
      end

      if (OPB_RE) begin
         if (reg_hit) begin
            case (reg_idx)
               2'd0:    do_d = {29'd0, cont_q, 2'b00};
               2'd1:    do_d = {16'd0, nsamp_q};
               2'd2:    do_d = {16'(wptr_q), 13'd0, ovf_q, done_q, busy};
               default: do_d = {16'd0, period_q};
            endcase
            if (reg_idx == 2'd2) begin
               done_d = 1'b0;
               ovf_d  = 1'b0;
            end
         end else if (ram_hit) begin
            do_d = mem[OPB_ADDR[AW+1:2]];
         end
      end

      // per_q counts cycles since the last CNVST rise; it is loaded with 1 on the rising edge itself
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               wptr_d     = '0;
               frame_d    = '0;
               run_cont_d = OPB_DI[2];
               target_d   = ({1'b0, nsamp_q} > FRAMES_MAX) ? FRAMES_MAX : {1'b0, nsamp_q};
               if (nsamp_q == 16'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_CONV;
                  cnt_d   = '0;
                  per_d   = 17'd1;
               end
            end
         end
         ST_CONV: begin
            if (cnt_q == CONVW'(CONV_CYC - 1)) begin
               state_d = ST_ACQ;
               cnt_d   = '0;
               div_d   = '0;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_ACQ: begin
            if (div_q == DIVW'(SCLK_DIV - 1)) begin
               div_d = '0;
               if (!sclk_q) begin
                  sclk_d = 1'b1;
                  for (int unsigned n = 0; n < NUM_CH; n++) begin
                     sh_d[n] = {sh_q[n][DATA_W-2:0], AD_SDOUT[n]};
                  end
               end else begin
                  sclk_d = 1'b0;
                  if (bit_q == BITW'(DATA_W - 1)) begin
                     state_d = ST_STORE;
                     st_d    = '0;
                  end else begin
                     bit_d = bit_q + 1'b1;
                  end
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         ST_STORE: begin
            mem_we = 1'b1;
            if (st_q == CHW'(NUM_CH - 1)) begin
               wptr_d  = wsum[AW-1:0];
               frame_d = frame_q + 17'd1;
               state_d = ST_WAIT;
               if (wsum[AW]) ovf_d = 1'b1;
            end else begin
               st_d = st_q + 1'b1;
            end
         end
         ST_WAIT: begin
            if (run_cont_q ? !cont_q : (frame_q >= target_q)) begin
               state_d = ST_DONE;
            end else if (per_q >= {1'b0, period_q}) begin
               state_d = ST_CONV;
               cnt_d   = '0;
               per_d   = 17'd1;
            end
         end
         ST_DONE: begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (soft_rst) begin
         state_d    = ST_IDLE;
         cont_d     = 1'b0;
         run_cont_d = 1'b0;
         nsamp_d    = '0;
         period_d   = '0;
         done_d     = 1'b0;
         ovf_d      = 1'b0;
         wptr_d     = '0;
         frame_d    = '0;
         target_d   = '0;
         per_d      = '0;
         cnt_d      = '0;
         div_d      = '0;
         bit_d      = '0;
         st_d       = '0;
         sclk_d     = 1'b0;
         sh_d       = '0;
         do_d       = '0;
         mem_we     = 1'b0;
      end

      cnvst_d = (state_d == ST_CONV);
   end

   always_ff @(posedge OPB_CLK or negedge OPB_RST_N) begin
      if (!OPB_RST_N) begin
         state_q    <= ST_IDLE;
         cont_q     <= 1'b0;
         run_cont_q <= 1'b0;
         nsamp_q    <= '0;
         period_q   <= '0;
         done_q     <= 1'b0;
         ovf_q      <= 1'b0;
         wptr_q     <= '0;
         frame_q    <= '0;
         target_q   <= '0;
         per_q      <= '0;
         cnt_q      <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         st_q       <= '0;
         sclk_q     <= 1'b0;
         cnvst_q    <= 1'b0;
         sh_q       <= '0;
         do_q       <= '0;
      end else begin
         state_q    <= state_d;
         cont_q     <= cont_d;
         run_cont_q <= run_cont_d;
         nsamp_q    <= nsamp_d;
         period_q   <= period_d;
         done_q     <= done_d;
         ovf_q      <= ovf_d;
         wptr_q     <= wptr_d;
         frame_q    <= frame_d;
         target_q   <= target_d;
         per_q      <= per_d;
         cnt_q      <= cnt_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         st_q       <= st_d;
         sclk_q     <= sclk_d;
         cnvst_q    <= cnvst_d;
         sh_q       <= sh_d;
         do_q       <= do_d;
      end
   end

   // Sample RAM is not reset; a CPU read in the same cycle as a store sees the old word
   always_ff @(posedge OPB_CLK) begin
      if (mem_we) mem[mem_wa] <= mem_wd;
   end

endmodule
